// File: rtl/memaddr_range_monitor_pkg.sv
// Shared constants and helpers for the multi-channel memory address range monitor.
//  - default timestamp / event-id widths of the diagnosis system
//  - flits per range config entry and access-mode encodings
//  - mode_permits(): does a range mode allow a given access direction
package memaddr_range_monitor_pkg;

    localparam int unsigned DIAGNOSIS_TIMESTAMP_WIDTH          = 16;
    localparam int unsigned DIAGNOSIS_EV_ID_WIDTH              = 8;
    localparam int unsigned DIAGNOSIS_MEMRANGE_FLITS_PER_ENTRY = 5;

    localparam int unsigned FLIT_W = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CH_W   = 3;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_BOTH  = 2'b11;

    // we = 1 for a write access, 0 for a read access
    function automatic logic mode_permits(input logic [1:0] mode, input logic we);
        logic ok;
        ok = 1'b0;
        if (mode != MODE_OFF) begin
            if (we) ok = (mode == MODE_WRITE) || (mode == MODE_BOTH);
            else    ok = (mode == MODE_READ)  || (mode == MODE_BOTH);
        end
        return ok;
    endfunction

endpackage

// File: rtl/diag_event_fifo.sv
// Event FIFO with a registered output stage and valid/ready pop handshake.
// Ports:
//  clk, rst        clock, asynchronous active-high reset
//  push, push_data write one entry (ignored when full unless popping)
//  full_c          all DEPTH entries occupied (output stage included)
//  empty_c         no entry anywhere in the FIFO
//  pop_ready       consumer accepts out_data this cycle
//  out_valid/data  registered head of the FIFO, stable until accepted
module diag_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full_c,
    output logic             empty_c,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] mem_cnt;

    logic pop_c;
    logic load_c;
    logic push_ok_c;

    // The output register counts as one of the DEPTH entries
    assign full_c    = (mem_cnt + CNT_W'(out_valid)) == CNT_W'(DEPTH);
    assign empty_c   = (mem_cnt == '0) && !out_valid;
    assign pop_c     = out_valid && pop_ready;
    assign load_c    = (!out_valid || pop_ready) && (mem_cnt != '0);
    assign push_ok_c = push && (!full_c || pop_c);

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok_c) mem[wr_ptr] <= push_data;
    end

    // Pointers, occupancy and output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load_c)    rd_ptr <= rd_ptr + PTR_W'(1);
            mem_cnt <= mem_cnt + CNT_W'(push_ok_c) - CNT_W'(load_c);
            if (load_c) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr];
            end else if (pop_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/memaddr_range_monitor.sv
// Multi-channel memory address range monitor.
// Watches N_CH SRAM ports against N_RANGES inclusive address windows and
// queues matched accesses as events {id, timestamp, address, channel}.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  diag_sys_enabled    capture enable for new accesses
//  conf_flat_in        range config, entry r at flits 5r..5r+4
//  mem_addr/ce/we      per-channel SRAM access
//  time_global         global timestamp
//  ev_valid/ev_ready   event handshake towards the LUT
//  ev_id/time/addr/ch  event payload
//  lost_cnt, clr_lost  saturating count of dropped events and its clear
module memaddr_range_monitor
    import memaddr_range_monitor_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned N_RANGES   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_W       = DIAGNOSIS_TIMESTAMP_WIDTH,
    parameter int unsigned ID_W       = DIAGNOSIS_EV_ID_WIDTH,
    localparam int unsigned CONF_SIZE = DIAGNOSIS_MEMRANGE_FLITS_PER_ENTRY * N_RANGES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       diag_sys_enabled,
    input  logic [FLIT_W*CONF_SIZE-1:0] conf_flat_in,
    input  logic [ADDR_W*N_CH-1:0]     mem_addr,
    input  logic [N_CH-1:0]            mem_ce,
    input  logic [N_CH-1:0]            mem_we,
    input  logic [TS_W-1:0]            time_global,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [ID_W-1:0]            ev_id,
    output logic [TS_W-1:0]            ev_time,
    output logic [ADDR_W-1:0]          ev_addr,
    output logic [CH_W-1:0]            ev_ch,
    output logic [15:0]                lost_cnt,
    input  logic                       clr_lost
);

    localparam int unsigned FPE  = DIAGNOSIS_MEMRANGE_FLITS_PER_ENTRY;
    localparam int unsigned EV_W = ID_W + TS_W + ADDR_W + CH_W;
    localparam int unsigned RR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // S0 access registers
    logic [ADDR_W-1:0] s0_addr [N_CH];
    logic [N_CH-1:0]   s0_we;
    logic [N_CH-1:0]   s0_vld;
    logic [TS_W-1:0]   s0_time;

    // Decoded configuration
    logic [ID_W-1:0]     cfg_id [N_RANGES];
    logic [N_RANGES-1:0] conf_unused;

    // Compare results and pending slots
    logic [N_RANGES-1:0] hit_c [N_CH];
    logic [N_CH-1:0]     new_match_c;
    logic [EV_W-1:0]     new_ev_c [N_CH];
    logic [N_CH-1:0]     drop_c;
    logic [N_CH-1:0]     pend_v;
    logic [EV_W-1:0]     pend_ev [N_CH];

    // Arbiter
    logic [RR_W-1:0] rr_ptr;
    logic [RR_W-1:0] gidx_c;
    logic [N_CH-1:0] grant_c;
    logic            any_grant_c;
    logic            fifo_full_c;
    logic            fifo_empty_c;
    logic            fifo_can_push_c;

    logic [3:0]  drop_sum_c;
    logic [16:0] lost_sum_c;

    // S0: sample accesses; disabled capture leaves the slot invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(N_CH); c++) s0_addr[c] <= '0;
            s0_we   <= '0;
            s0_vld  <= '0;
            s0_time <= '0;
        end else begin
            for (int c = 0; c < int'(N_CH); c++) s0_addr[c] <= mem_addr[ADDR_W*c +: ADDR_W];
            s0_we   <= mem_we;
            s0_vld  <= mem_ce & {N_CH{diag_sys_enabled}};
            s0_time <= time_global;
        end
    end

    // S1: per-range decode and comparators for every channel
    for (genvar r = 0; r < int'(N_RANGES); r++) begin : g_cfg
        logic [FLIT_W-1:0] f0;
        logic [ADDR_W-1:0] lo;
        logic [ADDR_W-1:0] hi;

        assign f0 = conf_flat_in[FLIT_W*(FPE*r) +: FLIT_W];
        assign lo = {conf_flat_in[FLIT_W*(FPE*r+2) +: FLIT_W], conf_flat_in[FLIT_W*(FPE*r+1) +: FLIT_W]};
        assign hi = {conf_flat_in[FLIT_W*(FPE*r+4) +: FLIT_W], conf_flat_in[FLIT_W*(FPE*r+3) +: FLIT_W]};
        assign cfg_id[r] = f0[ID_W-1:0];

        // Reserved flit bits between the id field and the mode field
        if (ID_W < 13) begin : g_rsv
            assign conf_unused[r] = ^f0[12:ID_W];
        end else begin : g_norsv
            assign conf_unused[r] = 1'b0;
        end

        // lo > hi makes both bounds unsatisfiable together, so it never matches
        for (genvar c = 0; c < int'(N_CH); c++) begin : g_hit
            assign hit_c[c][r] = f0[15] && s0_vld[c] && mode_permits(f0[14:13], s0_we[c])
                              && (s0_addr[c] >= lo) && (s0_addr[c] <= hi);
        end
    end

    // S1: lowest-index hit wins, one candidate event per channel
    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        logic            match_c;
        logic [ID_W-1:0] id_sel_c;

        always_comb begin
            match_c  = 1'b0;
            id_sel_c = '0;
            for (int i = 0; i < int'(N_RANGES); i++) begin
                if (hit_c[c][i] && !match_c) begin
                    match_c  = 1'b1;
                    id_sel_c = cfg_id[i];
                end
            end
        end

        assign new_match_c[c] = match_c;
        assign new_ev_c[c]    = {id_sel_c, s0_time, s0_addr[c], CH_W'(c)};
        // Occupied slot that is not leaving this cycle cannot take the new event
        assign drop_c[c]      = match_c && pend_v[c] && !grant_c[c];
    end

    // Pending slot per channel, refilled in the same cycle it is granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v <= '0;
            for (int c = 0; c < int'(N_CH); c++) pend_ev[c] <= '0;
        end else begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (new_match_c[c] && (!pend_v[c] || grant_c[c])) begin
                    pend_v[c]  <= 1'b1;
                    pend_ev[c] <= new_ev_c[c];
                end else if (grant_c[c]) begin
                    pend_v[c]  <= 1'b0;
                end
            end
        end
    end

    // S2: a full FIFO still accepts when its head leaves this cycle
    assign fifo_can_push_c = !fifo_full_c || (ev_valid && ev_ready);

    // S2: round-robin search starting at rr_ptr
    always_comb begin
        logic        found;
        int unsigned idx;
        found   = 1'b0;
        idx     = 0;
        gidx_c  = '0;
        grant_c = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            idx = (int'(rr_ptr) + k) % int'(N_CH);
            if (!found && pend_v[idx]) begin
                found  = 1'b1;
                gidx_c = RR_W'(idx);
            end
        end
        if (found && fifo_can_push_c) grant_c[gidx_c] = 1'b1;
    end

    assign any_grant_c = |grant_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_grant_c) begin
            rr_ptr <= (int'(gidx_c) == int'(N_CH) - 1) ? '0 : gidx_c + RR_W'(1);
        end
    end

    // Saturating lost-event counter, clear wins over same-cycle drops
    always_comb begin
        drop_sum_c = '0;
        for (int c = 0; c < int'(N_CH); c++) drop_sum_c = drop_sum_c + 4'(drop_c[c]);
        lost_sum_c = {1'b0, lost_cnt} + 17'(drop_sum_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                lost_cnt <= '0;
        else if (clr_lost)      lost_cnt <= '0;
        else if (lost_sum_c[16]) lost_cnt <= 16'hFFFF;
        else                    lost_cnt <= lost_sum_c[15:0];
    end

    diag_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (any_grant_c),
        .push_data (pend_ev[gidx_c]),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .pop_ready (ev_ready),
        .out_valid (ev_valid),
        .out_data  ({ev_id, ev_time, ev_addr, ev_ch})
    );

    logic fifo_status_unused;
    assign fifo_status_unused = fifo_empty_c ^ (^conf_unused);

endmodule

// File: tb/tb_memaddr_range_monitor.sv
// Scoreboard bench for memaddr_range_monitor: stimulus pushes hand-computed
// expected events, a negedge monitor pops and compares on every accepted event.
module tb_memaddr_range_monitor;

    localparam int unsigned N_CH = 2;
    localparam int unsigned N_RANGES = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TS_W = 16;
    localparam int unsigned ID_W = 8;
    localparam int unsigned CONF_SIZE = 5 * N_RANGES;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] ts;
        logic [31:0]     addr;
        logic [2:0]      ch;
    } ev_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    diag_sys_enabled;
    logic [16*CONF_SIZE-1:0] conf_flat_in;
    logic [32*N_CH-1:0]      mem_addr;
    logic [N_CH-1:0]         mem_ce;
    logic [N_CH-1:0]         mem_we;
    logic [TS_W-1:0]         time_global = '0;
    logic                    ev_valid;
    logic                    ev_ready;
    logic [ID_W-1:0]         ev_id;
    logic [TS_W-1:0]         ev_time;
    logic [31:0]             ev_addr;
    logic [2:0]              ev_ch;
    logic [15:0]             lost_cnt;
    logic                    clr_lost;

    ev_t sb[$];
    ev_t mon_exp;
    int  n_cmp  = 0;
    int  n_fail = 0;

    memaddr_range_monitor #(
        .N_CH       (N_CH),
        .N_RANGES   (N_RANGES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TS_W       (TS_W),
        .ID_W       (ID_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .diag_sys_enabled (diag_sys_enabled),
        .conf_flat_in     (conf_flat_in),
        .mem_addr         (mem_addr),
        .mem_ce           (mem_ce),
        .mem_we           (mem_we),
        .time_global      (time_global),
        .ev_valid         (ev_valid),
        .ev_ready         (ev_ready),
        .ev_id            (ev_id),
        .ev_time          (ev_time),
        .ev_addr          (ev_addr),
        .ev_ch            (ev_ch),
        .lost_cnt         (lost_cnt),
        .clr_lost         (clr_lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) time_global <= time_global + 16'd1;

    // Monitor: every accepted event must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got id=%0h ts=%0h addr=%0h ch=%0d, required no event",
                         ev_id, ev_time, ev_addr, ev_ch);
            end else begin
                mon_exp = sb.pop_front();
                if ({ev_id, ev_time, ev_addr, ev_ch} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL event: got id=%0h ts=%0h addr=%0h ch=%0d, required id=%0h ts=%0h addr=%0h ch=%0d",
                             ev_id, ev_time, ev_addr, ev_ch, mon_exp.id, mon_exp.ts, mon_exp.addr, mon_exp.ch);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic set_range(input int r, input logic v, input logic [1:0] mode,
                             input logic [7:0] id, input logic [31:0] lo, input logic [31:0] hi);
        conf_flat_in[16*(5*r)   +: 16] = {v, mode, 5'b0, id};
        conf_flat_in[16*(5*r+1) +: 16] = lo[15:0];
        conf_flat_in[16*(5*r+2) +: 16] = lo[31:16];
        conf_flat_in[16*(5*r+3) +: 16] = hi[15:0];
        conf_flat_in[16*(5*r+4) +: 16] = hi[31:16];
    endtask

    // One-cycle access; t returns the timestamp the DUT samples at that edge
    task automatic drive(input logic [1:0] ce, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1, output logic [15:0] t);
        mem_ce   = ce;
        mem_we   = we;
        mem_addr = {a1, a0};
        t        = time_global;
        cyc();
        mem_ce   = '0;
    endtask

    task automatic expect_ev(input logic [7:0] id, input logic [15:0] t,
                             input logic [31:0] a, input logic [2:0] ch);
        ev_t e;
        e.id = id; e.ts = t; e.addr = a; e.ch = ch;
        sb.push_back(e);
    endtask

    // Single-channel access; id 0 means no event is expected
    task automatic single(input int ch, input logic we, input logic [31:0] a, input logic [7:0] id);
        logic [15:0] t;
        if (ch == 0) drive(2'b01, {1'b0, we}, a, 32'h0, t);
        else         drive(2'b10, {we, 1'b0}, 32'h0, a, t);
        if (id != 8'h00) expect_ev(id, t, a, 3'(ch));
        idle(4);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            cyc();
            k++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d events outstanding, required 0", name, sb.size());
        end
        idle(4);
    endtask

    initial begin
        logic [15:0] t;
        rst = 1'b1;
        diag_sys_enabled = 1'b1;
        conf_flat_in = '0;
        mem_addr = '0;
        mem_ce = '0;
        mem_we = '0;
        ev_ready = 1'b1;
        clr_lost = 1'b0;
        idle(3);
        chk("reset_ev_valid", 32'(ev_valid), 32'h0);
        chk("reset_lost_cnt", 32'(lost_cnt), 32'h0);
        chk("reset_ev_id",    32'(ev_id),    32'h0);
        chk("reset_ev_addr",  ev_addr,       32'h0);
        rst = 1'b0;
        cyc();

        // Basic write match and latency
        set_range(0, 1'b1, 2'b10, 8'h05, 32'h1000, 32'h10FF);
        cyc();
        drive(2'b01, 2'b01, 32'h1080, 32'h0, t);
        expect_ev(8'h05, t, 32'h1080, 3'd0);
        cyc();
        chk("lat_after_e1", 32'(ev_valid), 32'h0);
        cyc();
        chk("lat_after_e2", 32'(ev_valid), 32'h0);
        cyc();
        chk("lat_after_e3", 32'(ev_valid), 32'h1);
        drain("basic_write");

        // Mode filtering and inverted window
        single(0, 1'b0, 32'h1080, 8'h00);
        set_range(0, 1'b1, 2'b11, 8'h05, 32'h1000, 32'h10FF);
        cyc();
        single(0, 1'b0, 32'h1080, 8'h05);
        set_range(0, 1'b1, 2'b11, 8'h05, 32'h2000, 32'h1000);
        cyc();
        single(0, 1'b0, 32'h1800, 8'h00);
        single(1, 1'b1, 32'h2000, 8'h00);
        single(0, 1'b1, 32'h1000, 8'h00);
        drain("mode_and_inverted");
        chk("inverted_no_event", 32'(ev_valid), 32'h0);

        // Priority and boundaries
        set_range(0, 1'b1, 2'b11, 8'h07, 32'h3000, 32'h30FF);
        set_range(1, 1'b1, 2'b11, 8'h09, 32'h2F00, 32'h3100);
        set_range(2, 1'b1, 2'b10, 8'h21, 32'h4000, 32'h40FF);
        cyc();
        single(0, 1'b1, 32'h3000, 8'h07);
        single(1, 1'b0, 32'h3000, 8'h07);
        single(0, 1'b0, 32'h2FFF, 8'h09);
        single(0, 1'b0, 32'h2F00, 8'h09);
        single(0, 1'b0, 32'h2EFF, 8'h00);
        single(0, 1'b0, 32'h3100, 8'h09);
        single(0, 1'b1, 32'h3101, 8'h00);
        single(0, 1'b1, 32'h4000, 8'h21);
        single(1, 1'b1, 32'h40FF, 8'h21);
        single(0, 1'b1, 32'h3FFF, 8'h00);
        single(1, 1'b1, 32'h4100, 8'h00);
        single(0, 1'b0, 32'h4000, 8'h00);
        drain("priority_boundaries");

        // Round-robin between channels
        chk("lost_before_rr", 32'(lost_cnt), 32'h0);
        drive(2'b11, 2'b11, 32'h4010, 32'h4020, t);
        expect_ev(8'h21, t, 32'h4010, 3'd0);
        expect_ev(8'h21, t, 32'h4020, 3'd1);
        idle(3);
        chk("rr_first_ch", 32'(ev_ch), 32'h0);
        cyc();
        chk("rr_second_valid", 32'(ev_valid), 32'h1);
        chk("rr_second_ch", 32'(ev_ch), 32'h1);
        drain("rr_pair1");
        single(0, 1'b1, 32'h4030, 8'h21);
        drain("rr_single");
        drive(2'b11, 2'b11, 32'h4040, 32'h4050, t);
        expect_ev(8'h21, t, 32'h4050, 3'd1);
        expect_ev(8'h21, t, 32'h4040, 3'd0);
        drain("rr_pair2");

        // Overflow with backpressure
        ev_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_ce   = 2'b01;
            mem_we   = 2'b01;
            mem_addr = {32'h0, 32'h4000 + 32'(4 * k)};
            if (k < 5) expect_ev(8'h21, time_global, 32'h4000 + 32'(4 * k), 3'd0);
            cyc();
        end
        mem_ce = '0;
        idle(6);
        chk("ovf_lost_cnt", 32'(lost_cnt), 32'h1);
        chk("ovf_valid_held", 32'(ev_valid), 32'h1);
        chk("ovf_addr_held", ev_addr, 32'h4000);
        ev_ready = 1'b1;
        drain("overflow_drain");
        chk("lost_after_drain", 32'(lost_cnt), 32'h1);
        clr_lost = 1'b1;
        cyc();
        clr_lost = 1'b0;
        chk("lost_cleared", 32'(lost_cnt), 32'h0);

        // Asynchronous reset while events are queued
        ev_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_ce   = 2'b01;
            mem_we   = 2'b01;
            mem_addr = {32'h0, 32'h4080 + 32'(4 * k)};
            cyc();
        end
        mem_ce = '0;
        idle(6);
        chk("pre_reset_lost", 32'(lost_cnt), 32'h1);
        chk("pre_reset_valid", 32'(ev_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(ev_valid), 32'h0);
        chk("async_reset_lost", 32'(lost_cnt), 32'h0);
        chk("async_reset_addr", ev_addr, 32'h0);
        cyc();
        rst = 1'b0;
        ev_ready = 1'b1;
        idle(8);
        chk("post_reset_empty", 32'(ev_valid), 32'h0);

        // Capture disabled
        diag_sys_enabled = 1'b0;
        drive(2'b11, 2'b11, 32'h4000, 32'h4004, t);
        idle(8);
        chk("disabled_no_event", 32'(ev_valid), 32'h0);
        chk("disabled_no_lost", 32'(lost_cnt), 32'h0);
        diag_sys_enabled = 1'b1;
        single(1, 1'b1, 32'h4008, 8'h21);
        drain("reenabled");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
